// File: rtl/pcie_rd_sched.sv
// PCIe read-request scheduler: splits a descriptor into MRRS/4KB-bounded read
// chunks, tags each chunk from a free pool, and tracks tag completions.
module pcie_rd_sched #(
  parameter int unsigned LOW_ADDDR_BITS = 14,
  parameter int unsigned TAG_COUNT      = 32
) (
  input  logic                      s_ul_clk,
  input  logic                      s_ul_aresetn,
  input  logic [2:0]                cfg_mrrs,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [28:0]               desc_busaddr,
  input  logic [LOW_ADDDR_BITS-1:0] desc_locaddr,
  input  logic [15:0]               desc_qwords,
  input  logic                      abort,
  output logic                      ul_ml_rvalid,
  input  logic                      ul_ml_rready,
  output logic [LOW_ADDDR_BITS-1:0] ul_ml_rlocaddr,
  output logic [28:0]               ul_ml_rbusaddr,
  output logic [8:0]                ul_ml_rlength,
  output logic [4:0]                ul_ml_rtag,
  input  logic                      ul_ml_tvalid,
  output logic                      ul_ml_tready,
  input  logic [4:0]                ul_ml_ttag,
  output logic                      busy,
  output logic                      done,
  output logic [5:0]                outstanding,
  output logic [7:0]                tag_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [32:0] MASK_W   = (33'd1 << TAG_COUNT) - 33'd1;
  localparam logic [31:0] TAG_MASK = MASK_W[31:0];

  logic [1:0]                state, state_d;
  logic                      rvalid_r, rvalid_d;
  logic [4:0]                rtag_r, rtag_d;
  logic                      abort_pend, abort_pend_d;
  logic                      done_r, done_d;
  logic [31:0]               alloc, alloc_d;
  logic [5:0]                outstanding_r, outstanding_d;
  logic [7:0]                tag_err_r, tag_err_d;

  logic [28:0]               busaddr_r;
  logic [LOW_ADDDR_BITS-1:0] locaddr_r;
  logic [15:0]               remaining;
  logic [9:0]                chunk;

  logic [2:0]                mrrs_eff;
  logic [9:0]                max_qw, bound, rem_cap, chunk_calc;
  logic [31:0]               avail;
  logic [4:0]                low_tag;
  logic                      hs, ttag_in_range, free_ok, free_bad;
  logic [LOW_ADDDR_BITS-1:0] chunk_loc;

  // Chunk = min(remaining, MRRS, distance to next 4 KB bus boundary).
  always_comb begin
    mrrs_eff   = (cfg_mrrs > 3'd5) ? 3'd5 : cfg_mrrs;
    max_qw     = 10'd16 << mrrs_eff;
    bound      = 10'd512 - {1'b0, busaddr_r[8:0]};
    rem_cap    = (remaining > 16'd512) ? 10'd512 : remaining[9:0];
    chunk_calc = rem_cap;
    if (max_qw < chunk_calc) chunk_calc = max_qw;
    if (bound < chunk_calc)  chunk_calc = bound;
  end

  always_comb begin
    avail   = ~alloc & TAG_MASK;
    low_tag = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (avail[i]) low_tag = 5'(i);
    end
  end

  assign hs            = rvalid_r & ul_ml_rready;
  assign ttag_in_range = ({27'd0, ul_ml_ttag} < TAG_COUNT);
  assign free_ok       = ul_ml_tvalid & ttag_in_range & alloc[ul_ml_ttag];
  assign free_bad      = ul_ml_tvalid & ~free_ok;
  assign chunk_loc     = LOW_ADDDR_BITS'(chunk);

  always_comb begin
    state_d      = state;
    rvalid_d     = rvalid_r;
    rtag_d       = rtag_r;
    abort_pend_d = abort_pend;
    done_d       = 1'b0;
    unique case (state)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (desc_valid) state_d = CALC;
      end
      CALC: begin
        state_d = (abort || remaining == 16'd0) ? DRAIN : ISSUE;
      end
      ISSUE: begin
        if (rvalid_r) begin
          // An abort seen while a request is pending waits for its handshake.
          if (abort) abort_pend_d = 1'b1;
          if (ul_ml_rready) begin
            rvalid_d = 1'b0;
            state_d  = (abort || abort_pend) ? DRAIN : CALC;
          end
        end else if (abort) begin
          state_d = DRAIN;
        end else if (|avail) begin
          rvalid_d = 1'b1;
          rtag_d   = low_tag;
        end
      end
      DRAIN: begin
        if (outstanding_r == 6'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alloc_d = alloc;
    if (free_ok) alloc_d[ul_ml_ttag] = 1'b0;
    if (hs)      alloc_d[rtag_r]     = 1'b1;
    case ({hs, free_ok})
      2'b10:   outstanding_d = outstanding_r + 6'd1;
      2'b01:   outstanding_d = outstanding_r - 6'd1;
      default: outstanding_d = outstanding_r;
    endcase
    tag_err_d = tag_err_r;
    if (free_bad && tag_err_r != 8'hFF) tag_err_d = tag_err_r + 8'd1;
  end

  always_ff @(posedge s_ul_clk or negedge s_ul_aresetn) begin
    if (!s_ul_aresetn) begin
      state         <= IDLE;
      rvalid_r      <= 1'b0;
      rtag_r        <= 5'd0;
      abort_pend    <= 1'b0;
      done_r        <= 1'b0;
      alloc         <= 32'd0;
      outstanding_r <= 6'd0;
      tag_err_r     <= 8'd0;
    end else begin
      state         <= state_d;
      rvalid_r      <= rvalid_d;
      rtag_r        <= rtag_d;
      abort_pend    <= abort_pend_d;
      done_r        <= done_d;
      alloc         <= alloc_d;
      outstanding_r <= outstanding_d;
      tag_err_r     <= tag_err_d;
    end
  end

  always_ff @(posedge s_ul_clk) begin
    if (state == IDLE && desc_valid) begin
      busaddr_r <= desc_busaddr;
      locaddr_r <= desc_locaddr;
      remaining <= desc_qwords;
    end else if (hs) begin
      busaddr_r <= busaddr_r + {19'd0, chunk};
      locaddr_r <= locaddr_r + chunk_loc;
      remaining <= remaining - {6'd0, chunk};
    end
    if (state == CALC) chunk <= chunk_calc;
  end

  assign desc_ready     = (state == IDLE) & s_ul_aresetn;
  assign busy           = (state != IDLE);
  assign done           = done_r;
  assign outstanding    = outstanding_r;
  assign tag_err        = tag_err_r;
  assign ul_ml_tready   = 1'b1;
  assign ul_ml_rvalid   = rvalid_r;
  assign ul_ml_rtag     = rtag_r;
  assign ul_ml_rbusaddr = busaddr_r;
  assign ul_ml_rlocaddr = locaddr_r + chunk_loc;
  assign ul_ml_rlength  = 9'(chunk - 10'd1);

endmodule
